// File: rtl/first_one_pkg.sv
// Shared constants and helpers for the first-one isolation unit.
// Variant names and the index-width function used by core and top.
package first_one_pkg;

    localparam string VARIANT_SMALL = "small";
    localparam string VARIANT_FAST  = "fast";

    // Binary index width, never below one bit so WIDTH = 1 still has a port.
    function automatic int index_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/first_one_core.sv
// Combinational lowest-set-bit isolation, data -> one-hot mask.
// VARIANT selects a ripple chain ("small") or a prefix-OR network ("fast").
module first_one_core
    import first_one_pkg::*;
#(
    parameter int    WIDTH   = 8,
    parameter string VARIANT = VARIANT_FAST
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] mask_o
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    if (VARIANT == VARIANT_SMALL) begin : g_small
        logic seen;

        // Ripple a running "seen" flag from bit 0 upward.
        always_comb begin
            seen   = 1'b0;
            mask_o = '0;
            for (int i = 0; i < WIDTH; i++) begin
                mask_o[i] = data_i[i] & ~seen;
                seen      = seen | data_i[i];
            end
        end
    end else if (VARIANT == VARIANT_FAST) begin : g_fast
        logic [WIDTH-1:0] pfx;
        logic [WIDTH-1:0] excl;

        // Kogge-Stone inclusive prefix OR in LEVELS doubling steps.
        always_comb begin
            pfx = data_i;
            for (int k = 0; k < LEVELS; k++) begin
                pfx = pfx | (pfx << (1 << k));
            end
        end

        // Exclusive prefix: any set bit strictly below position i.
        assign excl   = pfx << 1;
        assign mask_o = data_i & ~excl;
    end else begin : g_bad
        $error("first_one_core: VARIANT must be \"small\" or \"fast\"");
        assign mask_o = '0;
    end

endmodule

// File: rtl/first_one_unit.sv
// Registered lowest-set-bit isolation with found flag, 1-cycle latency.
// FIRST_ONE_INDEX_OUTPUT_EN adds a registered binary index output.
module first_one_unit
    import first_one_pkg::*;
#(
    parameter int    WIDTH   = 8,
    parameter string VARIANT = VARIANT_FAST
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] first_one,
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
    output logic [index_width(WIDTH)-1:0] first_one_index,
`endif
    output logic             found
);

    logic [WIDTH-1:0] first_one_d, first_one_q;
    logic             found_d, found_q;

    first_one_core #(
        .WIDTH   (WIDTH),
        .VARIANT (VARIANT)
    ) u_core (
        .data_i (data),
        .mask_o (first_one_d)
    );

    assign found_d = |data;

    // Output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_one_q <= '0;
            found_q     <= 1'b0;
        end else begin
            first_one_q <= first_one_d;
            found_q     <= found_d;
        end
    end

    assign first_one = first_one_q;
    assign found     = found_q;

`ifdef FIRST_ONE_INDEX_OUTPUT_EN
    localparam int IW = index_width(WIDTH);

    logic [IW-1:0] index_d, index_q;

    // OR-tree encoder: one-hot mask makes OR of positions the exact index.
    always_comb begin
        index_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            index_d = index_d | (IW'(i) & {IW{first_one_d[i]}});
        end
    end

    // Index register, same latency as the mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign first_one_index = index_q;
`endif

endmodule

// File: tb/tb_first_one_unit.sv
// Directed and swept checks of first_one_unit, both variants, several widths.
// Optional index output is checked when FIRST_ONE_INDEX_OUTPUT_EN is defined.
module tb_first_one_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [7:0]  d8  = '0;
    logic [0:0]  d1  = '0;
    logic [4:0]  d5  = '0;
    logic [15:0] d16 = '0;

    logic [7:0]  m8f, m8s;
    logic [0:0]  m1f, m1s;
    logic [4:0]  m5f, m5s;
    logic [15:0] m16f, m16s;
    logic        f8f, f8s, f1f, f1s, f5f, f5s, f16f, f16s;

`ifdef FIRST_ONE_INDEX_OUTPUT_EN
    logic [2:0] i8f, i8s;
    logic [0:0] i1f, i1s;
    logic [2:0] i5f, i5s;
    logic [3:0] i16f, i16s;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    first_one_unit #(.WIDTH(8), .VARIANT("fast")) u8f (
        .clock(clock), .reset(reset), .data(d8), .first_one(m8f),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i8f),
`endif
        .found(f8f));
    first_one_unit #(.WIDTH(8), .VARIANT("small")) u8s (
        .clock(clock), .reset(reset), .data(d8), .first_one(m8s),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i8s),
`endif
        .found(f8s));
    first_one_unit #(.WIDTH(1), .VARIANT("fast")) u1f (
        .clock(clock), .reset(reset), .data(d1), .first_one(m1f),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i1f),
`endif
        .found(f1f));
    first_one_unit #(.WIDTH(1), .VARIANT("small")) u1s (
        .clock(clock), .reset(reset), .data(d1), .first_one(m1s),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i1s),
`endif
        .found(f1s));
    first_one_unit #(.WIDTH(5), .VARIANT("fast")) u5f (
        .clock(clock), .reset(reset), .data(d5), .first_one(m5f),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i5f),
`endif
        .found(f5f));
    first_one_unit #(.WIDTH(5), .VARIANT("small")) u5s (
        .clock(clock), .reset(reset), .data(d5), .first_one(m5s),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i5s),
`endif
        .found(f5s));
    first_one_unit #(.WIDTH(16), .VARIANT("fast")) u16f (
        .clock(clock), .reset(reset), .data(d16), .first_one(m16f),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i16f),
`endif
        .found(f16f));
    first_one_unit #(.WIDTH(16), .VARIANT("small")) u16s (
        .clock(clock), .reset(reset), .data(d16), .first_one(m16s),
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        .first_one_index(i16s),
`endif
        .found(f16s));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lsb_mask(input logic [31:0] d, input int w);
        for (int i = 0; i < w; i++) if (d[i]) return 32'(1) << i;
        return 32'd0;
    endfunction

    function automatic logic [31:0] lsb_idx(input logic [31:0] d, input int w);
        for (int i = 0; i < w; i++) if (d[i]) return 32'(i);
        return 32'd0;
    endfunction

    // Compare every instance against the model for the inputs now held.
    task automatic verify(input string tag);
        check({tag, " m8f"},  32'(m8f),  lsb_mask(32'(d8), 8));
        check({tag, " m8s"},  32'(m8s),  lsb_mask(32'(d8), 8));
        check({tag, " f8f"},  32'(f8f),  32'(d8 != 0));
        check({tag, " f8s"},  32'(f8s),  32'(d8 != 0));
        check({tag, " m1f"},  32'(m1f),  32'(d1));
        check({tag, " m1s"},  32'(m1s),  32'(d1));
        check({tag, " f1f"},  32'(f1f),  32'(d1));
        check({tag, " f1s"},  32'(f1s),  32'(d1));
        check({tag, " m5f"},  32'(m5f),  lsb_mask(32'(d5), 5));
        check({tag, " m5s"},  32'(m5s),  lsb_mask(32'(d5), 5));
        check({tag, " f5f"},  32'(f5f),  32'(d5 != 0));
        check({tag, " f5s"},  32'(f5s),  32'(d5 != 0));
        check({tag, " m16f"}, 32'(m16f), lsb_mask(32'(d16), 16));
        check({tag, " m16s"}, 32'(m16s), lsb_mask(32'(d16), 16));
        check({tag, " f16f"}, 32'(f16f), 32'(d16 != 0));
        check({tag, " f16s"}, 32'(f16s), 32'(d16 != 0));
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        check({tag, " i8f"},  32'(i8f),  lsb_idx(32'(d8), 8));
        check({tag, " i8s"},  32'(i8s),  lsb_idx(32'(d8), 8));
        check({tag, " i1f"},  32'(i1f),  32'd0);
        check({tag, " i1s"},  32'(i1s),  32'd0);
        check({tag, " i5f"},  32'(i5f),  lsb_idx(32'(d5), 5));
        check({tag, " i5s"},  32'(i5s),  lsb_idx(32'(d5), 5));
        check({tag, " i16f"}, 32'(i16f), lsb_idx(32'(d16), 16));
        check({tag, " i16s"}, 32'(i16s), lsb_idx(32'(d16), 16));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] c16 [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};

    initial begin
        // Reset state while held.
        tick();
        check("rst m8f", 32'(m8f), 32'h00);
        check("rst f8f", 32'(f8f), 32'h0);
        check("rst m16s", 32'(m16s), 32'h0);

        reset = 1'b0;
        d8 = 8'hFF;
        tick();
        check("pre m8f", 32'(m8f), 32'h01);

        // Asynchronous reset mid-cycle clears outputs without an edge.
        #2;
        d8 = 8'b1010_0000;
        reset = 1'b1;
        #1;
        check("async m8f", 32'(m8f), 32'h00);
        check("async m8s", 32'(m8s), 32'h00);
        check("async f8f", 32'(f8f), 32'h0);
        reset = 1'b0;
        tick();
        check("rel m8f", 32'(m8f), 32'h20);
        check("rel m8s", 32'(m8s), 32'h20);
        check("rel f8f", 32'(f8f), 32'h1);

        // Boundaries, hand-computed.
        d8 = 8'h00; tick();
        check("b00 m", 32'(m8f), 32'h00);
        check("b00 f", 32'(f8s), 32'h0);
        d8 = 8'hFF; tick();
        check("bFF m", 32'(m8s), 32'h01);
        d8 = 8'h80; tick();
        check("b80 m", 32'(m8f), 32'h80);
        d8 = 8'h01; tick();
        check("b01 m", 32'(m8s), 32'h01);
        d8 = 8'b0110_1100; tick();
        check("b6C m", 32'(m8f), 32'h04);
        d8 = 8'b0011_0000; tick();
        check("b30 m", 32'(m8s), 32'h10);
`ifdef FIRST_ONE_INDEX_OUTPUT_EN
        check("b30 idx", 32'(i8f), 32'd4);
        d8 = 8'h00; tick();
        check("b00 idx", 32'(i8s), 32'd0);
        check("b00 fnd", 32'(f8s), 32'd0);
`endif

        // Back-to-back throughput.
        d8 = 8'h06; tick();
        check("bb0", 32'(m8f), 32'h02);
        d8 = 8'h40; tick();
        check("bb1", 32'(m8f), 32'h40);
        d8 = 8'h00; tick();
        check("bb2", 32'(m8f), 32'h00);

        // 16-bit corners.
        for (int i = 0; i < 4; i++) begin
            d16 = c16[i];
            tick();
            verify("c16");
        end

        // Exhaustive 8-bit sweep, 5/1-bit exhaustive, 16-bit random.
        for (int v = 0; v < 256; v++) begin
            d8  = 8'(v);
            d5  = 5'(v);
            d1  = 1'(v);
            d16 = 16'($urandom);
            if (v[3:0] == 4'd5) d16 = 16'(1) << (v >> 4);
            tick();
            verify("sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/first_one_unit.md
Name:
first_one_unit

Overview:
- Isolates the lowest-index set bit of a data vector and outputs it as a one-hot mask; all-zero input gives an all-zero mask.
- Output is registered, so it can sit directly on an arbiter or priority path inside a clocked pipeline.
- Two selectable combinational architectures: an area-optimised ripple chain ("small") and a log-depth parallel-prefix network ("fast").

Parameters:
- WIDTH, 8, data and mask width in bits; ≥ 1.
- VARIANT, "fast", combinational architecture, "small" or "fast". Any other value is an elaboration-time $error.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  WIDTH  vector to scan; bit 0 has highest priority.
- first_one  output  WIDTH  registered one-hot mask of the lowest set bit of data; all-zero if data == 0.
- found  output  1  registered; 1 when data had at least one bit set.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while reset = 1, first_one = '0 and found = 0, independent of clock.
- Core function (combinational, next-state): first_one_next[i] = data[i] & ~|data[i-1:0]; first_one_next[0] = data[0]; found_next = |data.
- Latency: exactly 1 cycle. Output at edge N+1 reflects data sampled at edge N. New data accepted every cycle; no handshake, no stall.
- Output invariant: first_one is always one-hot or zero; found == |first_one.
- "small" variant: linear chain. A running "seen" signal propagates from bit 0 upward; seen[i] = seen[i-1] | data[i-1].
- "fast" variant: parallel-prefix OR (Kogge-Stone or Sklansky) of data gives the exclusive prefix in ceil(log2 WIDTH) levels; first_one_next = data & ~prefix.
- Both variants are bit-exact equivalent for all 2^WIDTH inputs.
- Boundaries:
  - data = all-zero → mask 0, found 0.
  - data = all-ones → mask = 1 (bit 0).
  - data with only MSB set → mask with only MSB set.
  - WIDTH = 1 → first_one = data, registered.
- Reset deasserting mid-stream: the first capture is on the first rising edge after deassertion. There is no dependence on earlier inputs.

Optional Feature:
- Macro FIRST_ONE_INDEX_OUTPUT_EN.
- Defined:
  - Adds output first_one_index, width max(1, $clog2(WIDTH)), registered with the same 1-cycle latency.
  - It carries the binary index of the lowest set bit, encoded from the one-hot mask by an OR-tree.
  - Value 0 when data == 0; disambiguate with found.
  - Reset value 0.
- Undefined: port and encoder logic are absent. Every other behaviour is identical.

Decomposition:
- Package first_one_pkg:
  - variant string constants VARIANT_SMALL and VARIANT_FAST;
  - function for index width, max(1, $clog2(WIDTH)).
- Sub-module first_one_core: purely combinational, parameters WIDTH and VARIANT, data → mask. It contains both generate branches.
- first_one_unit instantiates first_one_core and adds the output registers, the found flag and the optional index encoder.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with data = 8'b1010_0000 → first_one = 0, found = 0 immediately. After deassertion and one edge → first_one = 8'b0010_0000, found = 1.
- Exhaustive, both variants, WIDTH = 8: drive all 256 values, one per cycle. Compare first_one one cycle later against a loop model (lowest set bit, else 0), e.g. 8'b0110_1100 → 8'b0000_0100. Also check found.
- Boundaries: 8'h00 → 8'h00 with found 0; 8'hFF → 8'h01; 8'h80 → 8'h80; 8'h01 → 8'h01.
- Back-to-back throughput: data sequence 8'h06, 8'h40, 8'h00 on consecutive edges → outputs 8'h02, 8'h40, 8'h00 on the following consecutive edges.
- With FIRST_ONE_INDEX_OUTPUT_EN, run the exhaustive sweep: data = 8'b0011_0000 → index 4; 8'h00 → index 0 with found 0. Check index == position of the mask bit on every vector.
- Parameter sweep: WIDTH ∈ {1, 5, 16}, both variants, random plus corner vectors → variants match each other and the model.
